// File: rtl/data_compress.sv
// Lane compactor: packs the valid input lanes into the lowest output lanes,
// preserving their order, with an optional one-cycle output register.
module data_compress #(
    parameter int DW      = 32,
    parameter int N       = 8,
    parameter bit REG_OUT = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N-1:0]             i_valid,
    input  logic [DW-1:0]            i_data [N-1:0],
    output logic [DW-1:0]            o_data [N-1:0],
    output logic [N-1:0]             o_valid,
    output logic [$clog2(N+1)-1:0]   o_count
);

    localparam int CW = $clog2(N+1);

    logic [CW-1:0] dst_s   [N-1:0];
    logic [CW-1:0] count_s;
    logic [DW-1:0] data_s  [N-1:0];
    logic [N-1:0]  valid_s;

    // Running prefix popcount: a lane's destination is the number of valid lanes below it
    always_comb begin
        count_s = '0;
        for (int i = 0; i < N; i++) begin
            dst_s[i] = count_s;
            count_s  = count_s + {{(CW-1){1'b0}}, i_valid[i]};
        end
    end

    // Per-output AND-OR mux; invalid lanes are gated to zero so their data never leaks
    always_comb begin
        for (int k = 0; k < N; k++) begin
            data_s[k]  = '0;
            valid_s[k] = (CW'(k) < count_s);
            for (int i = 0; i < N; i++) begin
                data_s[k] = data_s[k] |
                            ((i_valid[i] && (dst_s[i] == CW'(k))) ? i_data[i] : {DW{1'b0}});
            end
        end
    end

    generate
        if (REG_OUT) begin : g_reg
            logic [DW-1:0] data_r [N-1:0];
            logic [N-1:0]  valid_r;
            logic [CW-1:0] count_r;

            // Output register; reset wins over the word group presented in the same cycle
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < N; k++) begin
                        data_r[k] <= '0;
                    end
                    valid_r <= '0;
                    count_r <= '0;
                end else begin
                    data_r  <= data_s;
                    valid_r <= valid_s;
                    count_r <= count_s;
                end
            end

            assign o_data  = data_r;
            assign o_valid = valid_r;
            assign o_count = count_r;
        end else begin : g_comb
            logic unused_s;
            assign unused_s = clk ^ rst;

            assign o_data  = data_s;
            assign o_valid = valid_s;
            assign o_count = count_s;
        end
    endgenerate

endmodule

// File: tb/tb_data_compress.sv
// Self-checking bench for data_compress: a combinational and a registered
// instance share stimulus and are compared against a queue-based model.
module tb_data_compress;

    localparam int DW = 32;
    localparam int N  = 8;
    localparam int CW = $clog2(N+1);

    logic          clk;
    logic          rst;
    logic [N-1:0]  i_valid;
    logic [DW-1:0] i_data    [N-1:0];
    logic [DW-1:0] o_data_c  [N-1:0];
    logic [N-1:0]  o_valid_c;
    logic [CW-1:0] o_count_c;
    logic [DW-1:0] o_data_r  [N-1:0];
    logic [N-1:0]  o_valid_r;
    logic [CW-1:0] o_count_r;

    int n_cmp;
    int n_fail;

    logic [DW-1:0] exp_data  [N-1:0];
    logic [N-1:0]  exp_valid;
    logic [CW-1:0] exp_count;

    data_compress #(.DW(DW), .N(N), .REG_OUT(1'b0)) u_comb (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_data  (o_data_c),
        .o_valid (o_valid_c),
        .o_count (o_count_c)
    );

    data_compress #(.DW(DW), .N(N), .REG_OUT(1'b1)) u_reg (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_data  (o_data_r),
        .o_valid (o_valid_r),
        .o_count (o_count_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: gather valid lanes in ascending order, left-justify, zero the rest
    task automatic model();
        logic [DW-1:0] q [$];
        logic [N:0]    one_hot;
        for (int i = 0; i < N; i++) begin
            if (i_valid[i]) q.push_back(i_data[i]);
        end
        for (int k = 0; k < N; k++) begin
            exp_data[k] = (k < q.size()) ? q[k] : 32'h0;
        end
        one_hot   = (N+1)'(1) << q.size();
        exp_valid = N'(one_hot - (N+1)'(1));
        exp_count = CW'(q.size());
    endtask

    // mode 0: i_data[i]=i; mode 1: random data on every lane (garbage on invalid lanes)
    task automatic step(input logic [N-1:0] v, input logic r, input bit mode);
        logic [N:0] sum;
        rst     = r;
        i_valid = v;
        for (int i = 0; i < N; i++) begin
            i_data[i] = mode ? DW'($urandom) : DW'(i);
        end
        #1;
        model();
        for (int k = 0; k < N; k++) begin
            check($sformatf("comb_data[%0d] v=%b", k, v), 64'(o_data_c[k]), 64'(exp_data[k]));
        end
        check($sformatf("comb_valid v=%b", v), 64'(o_valid_c), 64'(exp_valid));
        check($sformatf("comb_count v=%b", v), 64'(o_count_c), 64'(exp_count));
        sum = {1'b0, o_valid_c} + (N+1)'(1);
        check($sformatf("comb_thermo v=%b", v), 64'(sum), 64'((N+1)'(1) << $countones(v)));
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            check($sformatf("reg_data[%0d] v=%b rst=%b", k, v, r), 64'(o_data_r[k]),
                  r ? 64'h0 : 64'(exp_data[k]));
        end
        check($sformatf("reg_valid v=%b rst=%b", v, r), 64'(o_valid_r), r ? 64'h0 : 64'(exp_valid));
        check($sformatf("reg_count v=%b rst=%b", v, r), 64'(o_count_r), r ? 64'h0 : 64'(exp_count));
    endtask

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        rst     = 1'b1;
        i_valid = '0;
        for (int i = 0; i < N; i++) i_data[i] = '0;
        @(negedge clk);

        step(8'h00, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);

        step(8'b1010_0110, 1'b0, 1'b0);
        check("dir_a_data0", 64'(o_data_r[0]), 64'd1);
        check("dir_a_data1", 64'(o_data_r[1]), 64'd2);
        check("dir_a_data2", 64'(o_data_r[2]), 64'd5);
        check("dir_a_data3", 64'(o_data_r[3]), 64'd7);
        check("dir_a_data4", 64'(o_data_r[4]), 64'd0);
        check("dir_a_valid", 64'(o_valid_r), 64'h0F);
        check("dir_a_count", 64'(o_count_r), 64'd4);

        step(8'h00, 1'b0, 1'b0);
        check("dir_zero_count", 64'(o_count_c), 64'd0);

        step(8'hFF, 1'b0, 1'b0);
        check("dir_full_data7", 64'(o_data_c[7]), 64'd7);
        check("dir_full_count", 64'(o_count_c), 64'd8);

        step(8'b1000_0000, 1'b0, 1'b0);
        check("dir_top_data0", 64'(o_data_c[0]), 64'd7);
        check("dir_top_valid", 64'(o_valid_c), 64'h01);

        step(8'h01, 1'b0, 1'b0);
        check("dir_bot_valid", 64'(o_valid_c), 64'h01);

        step(8'b0101_0101, 1'b0, 1'b0);
        check("dir_55_data1", 64'(o_data_r[1]), 64'd2);
        check("dir_55_data3", 64'(o_data_r[3]), 64'd6);
        check("dir_55_valid", 64'(o_valid_r), 64'h0F);

        step(8'hA5, 1'b1, 1'b1);
        step(8'h3C, 1'b0, 1'b1);

        for (int t = 0; t < 300; t++) begin
            step(N'($urandom), ($urandom_range(0, 15) == 0), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
